// File: rtl/pipe_sched.sv
// Pipeline scheduler: arbitrates Req, bus wait, MDU busy and D hazards into register enables/bubbles.
// Latency: stall/flush controls are combinational (zero cycle); MDU, watchdog and stall counters are registered.
// Backpressure: a bus wait freezes PC..E/M and bubbles M/W; a D stall freezes PC/F/D and bubbles D/E.
module pipe_sched #(
    parameter int MULT_CYC    = 5,
    parameter int DIV_CYC     = 10,
    parameter int BUS_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Req,
    input  logic             D_hazard,
    input  logic             D_mdu_use,
    input  logic             E_mdu_start,
    input  logic             E_mdu_div,
    input  logic             M_mem_req,
    input  logic             mem_ready,
    output logic             PC_en,
    output logic             FD_en,
    output logic             DE_en,
    output logic             EM_en,
    output logic             DE_reset,
    output logic             MW_reset,
    output logic             mdu_busy,
    output logic             mdu_start_ok,
    output logic             bus_err,
    output logic             mem_abort,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int MDU_MAX = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int MDU_W   = $clog2(MDU_MAX + 1);
    localparam int WAIT_W  = $clog2(BUS_TIMEOUT + 1);

    localparam logic [MDU_W-1:0]  MULT_LOAD = MDU_W'(MULT_CYC);
    localparam logic [MDU_W-1:0]  DIV_LOAD  = MDU_W'(DIV_CYC);
    localparam logic [WAIT_W:0]   WAIT_LIM  = (WAIT_W + 1)'(BUS_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WAIT_W-1:0]  wait_q;
    logic [WAIT_W-1:0]  wait_d;
    logic [WAIT_W:0]    wait_inc;
    logic [MDU_W-1:0]   mdu_cnt_q;
    logic               mem_pending;
    logic               bus_wait;
    logic               d_stall;

    // Raw hazard terms shared by the output arbitration and the watchdog FSM.
    always_comb begin
        mem_pending = M_mem_req & ~mem_ready;
        bus_wait    = mem_pending & ~Req;
        mdu_busy    = (mdu_cnt_q != '0);
        d_stall     = D_hazard | (D_mdu_use & (mdu_busy | E_mdu_start));
    end

    // Priority arbitration of enables and bubbles: reset, Req, bus wait, D stall, run.
    always_comb begin
        PC_en        = 1'b1;
        FD_en        = 1'b1;
        DE_en        = 1'b1;
        EM_en        = 1'b1;
        DE_reset     = 1'b0;
        MW_reset     = 1'b0;
        mem_abort    = 1'b0;
        mdu_start_ok = 1'b0;
        if (reset) begin
            // Everything runs while the core is held in reset.
        end else if (Req) begin
            // Pipeline registers flush themselves; only report the abandoned access.
            mem_abort = mem_pending;
        end else if (bus_wait) begin
            PC_en    = 1'b0;
            FD_en    = 1'b0;
            DE_en    = 1'b0;
            EM_en    = 1'b0;
            MW_reset = 1'b1;
        end else if (d_stall) begin
            PC_en    = 1'b0;
            FD_en    = 1'b0;
            DE_reset = 1'b1;
        end
        // Operands are latched only when the E instruction actually advances.
        mdu_start_ok = E_mdu_start & EM_en & ~Req & ~reset;
    end

    // Watchdog next state: count consecutive wait cycles, flag ERR for one cycle on timeout.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        wait_inc = {1'b0, wait_q} + {{WAIT_W{1'b0}}, 1'b1};
        case (state_q)
            ST_RUN: begin
                if (bus_wait) begin
                    state_d = ST_WAIT;
                    wait_d  = {{(WAIT_W-1){1'b0}}, 1'b1};
                end else begin
                    wait_d = '0;
                end
            end
            ST_WAIT: begin
                if (bus_wait) begin
                    wait_d = wait_inc[WAIT_W-1:0];
                    if (wait_inc >= WAIT_LIM) begin
                        state_d = ST_ERR;
                    end
                end else begin
                    // mem_ready or Req releases the freeze.
                    state_d = ST_RUN;
                    wait_d  = '0;
                end
            end
            ST_ERR: begin
                state_d = ST_RUN;
                wait_d  = '0;
            end
            default: begin
                state_d = ST_RUN;
                wait_d  = '0;
            end
        endcase
    end

    // Watchdog state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign bus_err = (state_q == ST_ERR);

    // MDU busy window: load on an accepted start, otherwise count down to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            mdu_cnt_q <= '0;
        end else if (mdu_start_ok) begin
            mdu_cnt_q <= E_mdu_div ? DIV_LOAD : MULT_LOAD;
        end else if (mdu_cnt_q != '0) begin
            mdu_cnt_q <= mdu_cnt_q - 1'b1;
        end
    end

    // Saturating count of cycles in which the PC is frozen.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (!PC_en && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_sched.sv
// Bench for pipe_sched: directed scenarios with literal expectations plus a per-cycle reference model.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
// The reference model tracks MDU remaining cycles, consecutive wait cycles and stall count as integers.
module tb_pipe_sched;

    localparam int MULT_CYC    = 5;
    localparam int DIV_CYC     = 10;
    localparam int BUS_TIMEOUT = 4;
    localparam int CNT_W       = 16;
    localparam int SAT         = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             Req = 1'b0;
    logic             D_hazard = 1'b0;
    logic             D_mdu_use = 1'b0;
    logic             E_mdu_start = 1'b0;
    logic             E_mdu_div = 1'b0;
    logic             M_mem_req = 1'b0;
    logic             mem_ready = 1'b0;
    logic             PC_en, FD_en, DE_en, EM_en, DE_reset, MW_reset;
    logic             mdu_busy, mdu_start_ok, bus_err, mem_abort;
    logic [CNT_W-1:0] stall_cycles;

    pipe_sched #(
        .MULT_CYC   (MULT_CYC),
        .DIV_CYC    (DIV_CYC),
        .BUS_TIMEOUT(BUS_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Req         (Req),
        .D_hazard    (D_hazard),
        .D_mdu_use   (D_mdu_use),
        .E_mdu_start (E_mdu_start),
        .E_mdu_div   (E_mdu_div),
        .M_mem_req   (M_mem_req),
        .mem_ready   (mem_ready),
        .PC_en       (PC_en),
        .FD_en       (FD_en),
        .DE_en       (DE_en),
        .EM_en       (EM_en),
        .DE_reset    (DE_reset),
        .MW_reset    (MW_reset),
        .mdu_busy    (mdu_busy),
        .mdu_start_ok(mdu_start_ok),
        .bus_err     (bus_err),
        .mem_abort   (mem_abort),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;
    bit mdl_on = 1'b0;

    // Reference model state.
    int m_mdu   = 0;
    int m_wait  = 0;
    bit m_err   = 1'b0;
    int m_stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc_no, act, exp);
        end
    endtask

    // Expected {PC_en,FD_en,DE_en,EM_en,DE_reset,MW_reset,mdu_start_ok,mem_abort}.
    function automatic logic [7:0] exp_out();
        logic [7:0] r;
        logic       wt;
        logic       stl;
        wt  = M_mem_req & ~mem_ready;
        stl = D_hazard | (D_mdu_use & ((m_mdu != 0) | E_mdu_start));
        r   = 8'b1111_0000;
        if (reset)     r = 8'b1111_0000;
        else if (Req)  r[0] = wt;
        else if (wt)   r = 8'b0000_0100;
        else if (stl)  r = 8'b0011_1000;
        r[1] = E_mdu_start & r[4] & ~Req & ~reset;
        return r;
    endfunction

    // Model update on each rising edge from the inputs held during the cycle.
    always @(posedge clk) begin
        logic [7:0] e;
        e = exp_out();
        cyc_no++;
        if (reset) begin
            m_mdu   = 0;
            m_wait  = 0;
            m_err   = 1'b0;
            m_stall = 0;
        end else begin
            if (e[1])           m_mdu = E_mdu_div ? DIV_CYC : MULT_CYC;
            else if (m_mdu > 0) m_mdu = m_mdu - 1;
            if (m_err) begin
                m_err  = 1'b0;
                m_wait = 0;
            end else if (M_mem_req & ~mem_ready & ~Req) begin
                m_wait = m_wait + 1;
                if (m_wait >= BUS_TIMEOUT) m_err = 1'b1;
            end else begin
                m_wait = 0;
            end
            if (!e[7] && m_stall < SAT) m_stall = m_stall + 1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (mdl_on) begin
            chk("ctrl", 32'({PC_en, FD_en, DE_en, EM_en, DE_reset, MW_reset, mdu_start_ok, mem_abort}),
                32'(exp_out()));
            chk("mdu_busy", 32'(mdu_busy), 32'(m_mdu != 0));
            chk("bus_err", 32'(bus_err), 32'(m_err));
            chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        end
    end

    // Samples taken by the stimulus at the falling edge of each driven cycle.
    logic s_pc, s_fd, s_de, s_em, s_de_rst, s_mw, s_busy, s_ok, s_err, s_abort;
    logic [CNT_W-1:0] s_stall;
    int pc_low, busy_n, em_low, mw_high, err_n, err_idx;

    // Vector order: {Req, D_hazard, D_mdu_use, E_mdu_start, E_mdu_div, M_mem_req, mem_ready}.
    task automatic cyc(input logic [6:0] v);
        {Req, D_hazard, D_mdu_use, E_mdu_start, E_mdu_div, M_mem_req, mem_ready} = v;
        @(negedge clk);
        s_pc = PC_en;  s_fd = FD_en;  s_de = DE_en;  s_em = EM_en;
        s_de_rst = DE_reset;  s_mw = MW_reset;  s_busy = mdu_busy;
        s_ok = mdu_start_ok;  s_err = bus_err;  s_abort = mem_abort;
        s_stall = stall_cycles;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(7'b0);
        reset = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        mdl_on = 1'b1;
        do_reset();
        cyc(7'b0);
        chk("reset_pc_en", 32'(s_pc), 32'd1);
        chk("reset_stall", 32'(s_stall), 32'd0);
        chk("reset_busy", 32'(s_busy), 32'd0);
        chk("reset_err", 32'(s_err), 32'd0);

        // mult in E with mfhi in D: 6 frozen cycles, 5 busy cycles.
        do_reset();
        pc_low = 0; busy_n = 0;
        cyc(7'b0011000);
        chk("mult_start_ok", 32'(s_ok), 32'd1);
        if (!s_pc) pc_low++;
        if (s_busy) busy_n++;
        for (int i = 0; i < 9; i++) begin
            cyc(7'b0010000);
            if (!s_pc) pc_low++;
            if (s_busy) busy_n++;
        end
        chk("mult_pc_low", 32'(pc_low), 32'd6);
        chk("mult_busy_cycles", 32'(busy_n), 32'd5);
        chk("mult_stall_cycles", 32'(s_stall), 32'd6);

        // div start together with Req: never starts.
        do_reset();
        busy_n = 0;
        cyc(7'b1001100);
        chk("div_req_ok", 32'(s_ok), 32'd0);
        for (int i = 0; i < 12; i++) begin
            cyc(7'b0);
            if (s_busy) busy_n++;
        end
        chk("div_req_busy", 32'(busy_n), 32'd0);

        // Store with ready in the same cycle, then a 3-cycle wait.
        do_reset();
        cyc(7'b0000011);
        chk("ready_same_cycle_pc", 32'(s_pc), 32'd1);
        pc_low = 0; em_low = 0; mw_high = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(7'b0000010);
            if (!s_pc) pc_low++;
            if (!s_em) em_low++;
            if (s_mw) mw_high++;
        end
        cyc(7'b0000011);
        chk("wait_release_pc", 32'(s_pc), 32'd1);
        cyc(7'b0);
        chk("wait_pc_low", 32'(pc_low), 32'd3);
        chk("wait_em_low", 32'(em_low), 32'd3);
        chk("wait_mw_high", 32'(mw_high), 32'd3);
        chk("wait_stall_cycles", 32'(s_stall), 32'd3);

        // Timeout: bus_err after 4 wait cycles, then Req aborts the access.
        do_reset();
        err_n = 0; err_idx = -1;
        for (int i = 0; i < 5; i++) begin
            cyc(7'b0000010);
            if (s_err) begin
                err_n++;
                err_idx = i;
            end
        end
        cyc(7'b1000010);
        chk("timeout_abort", 32'(s_abort), 32'd1);
        chk("timeout_req_pc", 32'(s_pc), 32'd1);
        if (s_err) err_n++;
        cyc(7'b0);
        chk("timeout_err_count", 32'(err_n), 32'd1);
        chk("timeout_err_index", 32'(err_idx), 32'd4);

        // Req during WAIT releases in the same cycle and clears the watchdog.
        do_reset();
        cyc(7'b0000010);
        cyc(7'b0000010);
        cyc(7'b1000010);
        chk("req_in_wait_pc", 32'(s_pc), 32'd1);
        for (int i = 0; i < 3; i++) cyc(7'b0000010);
        chk("req_in_wait_no_err", 32'(s_err), 32'd0);
        cyc(7'b0000011);

        // Load-use hazard during a div: only F/D side affected, div keeps counting.
        do_reset();
        busy_n = 0;
        cyc(7'b0001100);
        for (int i = 0; i < 2; i++) begin
            cyc(7'b0100000);
            chk("haz_ctrl", 32'({s_pc, s_fd, s_de, s_em, s_de_rst, s_mw}), 32'(6'b001110));
            if (s_busy) busy_n++;
        end
        for (int i = 0; i < 12; i++) begin
            cyc(7'b0);
            if (s_busy) busy_n++;
        end
        chk("div_busy_cycles", 32'(busy_n), 32'd10);

        // Reset in the middle of a mult and in the middle of a wait.
        do_reset();
        cyc(7'b0001000);
        cyc(7'b0);
        reset = 1'b1;
        cyc(7'b0);
        reset = 1'b0;
        cyc(7'b0);
        chk("reset_mid_mdu_busy", 32'(s_busy), 32'd0);
        cyc(7'b0000010);
        cyc(7'b0000010);
        reset = 1'b1;
        cyc(7'b0000010);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc(7'b0000010);
        chk("reset_mid_wait_no_err", 32'(s_err), 32'd0);
        cyc(7'b0000011);

        // Saturation of the stall counter.
        do_reset();
        for (int i = 0; i < (1 << CNT_W) + 5; i++) cyc(7'b0100000);
        chk("stall_saturate", 32'(s_stall), 32'(SAT));
        cyc(7'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
